// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default sizing constants and the round-robin pointer helper.
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int GRANT_W         = 3;
    localparam int CNT_W           = 16;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Pointer to the requester after idx, wrapping at num_req.
    function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] idx,
                                                   input int num_req);
        if (int'(idx) >= num_req - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request at or after ptr,
// wrapping around to index 0. Purely combinational.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               found
);

    // Lower-than-ptr candidates are scanned first so any candidate at or
    // above ptr, found in the second pass, overrides them.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (GRANT_W'(i) < ptr)) begin
                idx   = GRANT_W'(i);
                found = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (GRANT_W'(i) >= ptr)) begin
                idx   = GRANT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte-stream requesters onto one uart_tx_buffer write
// port. A granted requester owns the port for a whole message (until its
// last byte) or until it goes idle for TIMEOUT cycles; bytes leave at most
// one every two cycles as a registered single-cycle strobe.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [BYTE_W*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]        reqLast,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      bufFull,
    output logic [BYTE_W-1:0]         data,
    output logic                      dataReady,
    output logic [GRANT_W-1:0]        grantId,
    output logic                      busy
);

    localparam logic [CNT_W:0] TIMEOUT_LIM = TIMEOUT[CNT_W:0];

    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               data_ready_q, data_ready_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               handshake;
    logic [CNT_W:0]     cnt_inc;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_found;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req  (reqValid),
        .ptr  (rr_ptr_q),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Decode the current owner into a one-hot mask and mux out its byte.
    always_comb begin
        grant_oh = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (grant_q == GRANT_W'(i));
            if (grant_q == GRANT_W'(i)) begin
                sel_data = reqData[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign sel_valid = |(reqValid & grant_oh);
    assign sel_last  = |(reqLast & grant_oh);
    assign handshake = (state_q == ST_SEND) && sel_valid && !bufFull;
    assign cnt_inc   = {1'b0, idle_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign reqReady  = ((state_q == ST_SEND) && !bufFull) ? (reqValid & grant_oh) : '0;

    // Next-state logic; the strobe defaults low so it can only last one cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        idle_cnt_d   = idle_cnt_q;
        data_d       = data_q;
        data_ready_d = 1'b0;
        last_d       = last_q;
        busy_d       = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_SEND;
                    grant_d    = pick_idx;
                    busy_d     = 1'b1;
                    idle_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    data_d       = sel_data;
                    data_ready_d = 1'b1;
                    last_d       = sel_last;
                    idle_cnt_d   = '0;
                    state_d      = ST_GAP;
                end else if (!bufFull) begin
                    if (cnt_inc >= TIMEOUT_LIM) begin
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        idle_cnt_d = '0;
                        rr_ptr_d   = next_ptr(grant_q, NUM_REQ);
                    end else begin
                        idle_cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            ST_GAP: begin
                if (last_q) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr(grant_q, NUM_REQ);
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any message and pending strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            idle_cnt_q   <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign data      = data_q;
    assign dataReady = data_ready_q;
    assign grantId   = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester sources pop their byte
// queues on handshakes, scenarios push the expected strobe order, and a
// monitor compares every dataReady strobe against that order.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   reqValid;
    logic [8*NR-1:0] reqData;
    logic [NR-1:0]   reqLast;
    logic [NR-1:0]   reqReady;
    logic            bufFull;
    logic [7:0]      data;
    logic            dataReady;
    logic [2:0]      grantId;
    logic            busy;

    int checks     = 0;
    int failures   = 0;
    int cycleCount = 0;
    int prevStrobe = -1;

    logic [8:0]  srcQ [NR][$];
    logic [10:0] expQ [$];
    int          strobeLog [$];

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .bufFull  (bufFull),
        .data     (data),
        .dataReady(dataReady),
        .grantId  (grantId),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue n bytes (low byte first) on requester r; optionally flag the final one as last.
    task automatic applyStimulus(input int r, input int n, input logic [31:0] bytes,
                                 input bit withLast);
        for (int k = 0; k < n; k++) begin
            srcQ[r].push_back({(withLast && (k == n - 1)), bytes[8*k +: 8]});
        end
    endtask

    task automatic expectByte(input int gid, input logic [7:0] b);
        expQ.push_back({3'(gid), b});
    endtask

    task automatic waitQueue(input int n, input int bound, input string name);
        int k = 0;
        while (expQ.size() > n && k < bound) begin
            @(posedge clk); #2;
            k++;
        end
        checkOutput(name, 32'(expQ.size() <= n), 32'd1);
    endtask

    task automatic waitIdle(input int bound, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            @(posedge clk); #2;
            k++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        bufFull = 1'b0;
        for (int r = 0; r < NR; r++) srcQ[r].delete();
        expQ.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Requester sources: present queue heads at negedge, pop on handshake just before posedge.
    initial begin
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (srcQ[r].size() > 0) begin
                    reqValid[r]        = 1'b1;
                    reqData[8*r +: 8]  = srcQ[r][0][7:0];
                    reqLast[r]         = srcQ[r][0][8];
                end else begin
                    reqValid[r]        = 1'b0;
                    reqData[8*r +: 8]  = 8'h00;
                    reqLast[r]         = 1'b0;
                end
            end
            #4;
            for (int r = 0; r < NR; r++) begin
                if (reqValid[r] && reqReady[r]) void'(srcQ[r].pop_front());
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(posedge clk); #1;
            if (dataReady === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected strobe: got data 0x%0h grant %0d, expected none",
                             data, grantId);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe data", 32'(data), 32'(e[7:0]));
                    checkOutput("strobe grant", 32'(grantId), 32'(e[10:8]));
                end
                checkOutput("strobe busy", 32'(busy), 32'd1);
                if (prevStrobe >= 0) begin
                    checkOutput("strobe spacing", 32'((cycleCount - prevStrobe) >= 2), 32'd1);
                end
                prevStrobe = cycleCount;
                strobeLog.push_back(cycleCount);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fallCycle;
        int lastStrobe;
        bufFull = 1'b0;
        rst     = 1'b1;

        $display("[TB] reset state");
        doReset();
        checkOutput("reset dataReady", 32'(dataReady), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset grantId", 32'(grantId), 32'd0);
        checkOutput("reset reqReady", 32'(reqReady), 32'd0);
        checkOutput("reset data", 32'(data), 32'd0);

        $display("[TB] single message A,B,C from req0");
        strobeLog.delete();
        applyStimulus(0, 3, 32'h00434241, 1'b1);
        expectByte(0, 8'h41);
        expectByte(0, 8'h42);
        expectByte(0, 8'h43);
        waitQueue(0, 40, "single drained");
        checkOutput("single busy in gap", 32'(busy), 32'd1);
        @(posedge clk); #2;
        checkOutput("single busy drop", 32'(busy), 32'd0);
        checkOutput("single strobe off", 32'(dataReady), 32'd0);
        checkOutput("single strobe count", 32'(strobeLog.size()), 32'd3);
        if (strobeLog.size() == 3) begin
            checkOutput("single gap 1", 32'(strobeLog[1] - strobeLog[0]), 32'd2);
            checkOutput("single gap 2", 32'(strobeLog[2] - strobeLog[1]), 32'd2);
        end

        $display("[TB] pointer at 1: req1 beats req0");
        applyStimulus(0, 2, 32'h00001110, 1'b1);
        applyStimulus(1, 2, 32'h00002120, 1'b1);
        expectByte(1, 8'h20);
        expectByte(1, 8'h21);
        expectByte(0, 8'h10);
        expectByte(0, 8'h11);
        waitQueue(0, 60, "ptr1 drained");
        waitIdle(10, "ptr1 idle");

        $display("[TB] contention req1 and req2 from reset");
        doReset();
        applyStimulus(1, 3, 32'h00535251, 1'b1);
        applyStimulus(2, 2, 32'h00006261, 1'b1);
        expectByte(1, 8'h51);
        expectByte(1, 8'h52);
        expectByte(1, 8'h53);
        expectByte(2, 8'h61);
        expectByte(2, 8'h62);
        waitQueue(0, 60, "contention drained");
        waitIdle(10, "contention idle");

        $display("[TB] backpressure on req0 message");
        applyStimulus(0, 3, 32'h00737271, 1'b1);
        expectByte(0, 8'h71);
        expectByte(0, 8'h72);
        expectByte(0, 8'h73);
        waitQueue(2, 20, "bp first byte");
        bufFull = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            checkOutput("bp no strobe", 32'(dataReady), 32'd0);
            checkOutput("bp busy held", 32'(busy), 32'd1);
            checkOutput("bp ready low", 32'(reqReady), 32'd0);
            checkOutput("bp grant held", 32'(grantId), 32'd0);
        end
        bufFull   = 1'b0;
        fallCycle = cycleCount;
        waitQueue(1, 20, "bp second byte");
        lastStrobe = strobeLog[$];
        checkOutput("bp accept latency", 32'(lastStrobe - fallCycle), 32'd1);
        waitQueue(0, 20, "bp drained");
        waitIdle(10, "bp idle");

        $display("[TB] timeout on req3");
        applyStimulus(3, 1, 32'h00000044, 1'b0);
        expectByte(3, 8'h44);
        waitQueue(0, 20, "timeout byte");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            checkOutput("timeout busy held", 32'(busy), 32'd1);
        end
        @(posedge clk); #2;
        checkOutput("timeout revoke", 32'(busy), 32'd0);
        checkOutput("timeout no strobe", 32'(dataReady), 32'd0);

        $display("[TB] pointer at 0 after timeout");
        applyStimulus(1, 1, 32'h00000002, 1'b1);
        applyStimulus(0, 1, 32'h00000001, 1'b1);
        expectByte(0, 8'h01);
        expectByte(1, 8'h02);
        waitQueue(0, 40, "ptr0 drained");
        waitIdle(10, "ptr0 idle");
        applyStimulus(2, 1, 32'h00000003, 1'b1);
        expectByte(2, 8'h03);
        waitQueue(0, 20, "ptr2 drained");
        waitIdle(10, "ptr2 idle");

        $display("[TB] wrap from pointer 3 with all valid");
        applyStimulus(3, 2, 32'h00003130, 1'b1);
        applyStimulus(0, 1, 32'h00000080, 1'b1);
        applyStimulus(1, 1, 32'h00000090, 1'b1);
        applyStimulus(2, 1, 32'h000000A0, 1'b1);
        expectByte(3, 8'h30);
        expectByte(3, 8'h31);
        expectByte(0, 8'h80);
        expectByte(1, 8'h90);
        expectByte(2, 8'hA0);
        waitQueue(0, 80, "wrap drained");
        waitIdle(10, "wrap idle");

        $display("[TB] reset during second byte");
        applyStimulus(0, 3, 32'h00B2B1B0, 1'b1);
        expectByte(0, 8'hB0);
        waitQueue(0, 20, "rst first byte");
        @(posedge clk); #2;
        checkOutput("rst pre ready", 32'(reqReady), 32'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("rst dataReady", 32'(dataReady), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst grantId", 32'(grantId), 32'd0);
        checkOutput("rst reqReady", 32'(reqReady), 32'd0);
        for (int r = 0; r < NR; r++) srcQ[r].delete();
        @(posedge clk); #2;
        rst = 1'b0;
        checkOutput("rst strobe cleared", 32'(dataReady), 32'd0);
        repeat (6) @(posedge clk);
        #2;
        checkOutput("rst stays idle", 32'(busy), 32'd0);
        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of requesters; legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, 255, idle cycles mid-message before the grant is revoked; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port reqValid, input, NUM_REQ, per-requester byte valid.
REQ-006 SHALL have port reqData, input, 8*NUM_REQ, per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port reqLast, input, NUM_REQ, marks the final byte of a message; sampled with reqValid.
REQ-008 SHALL have port reqReady, output, NUM_REQ, byte accepted this cycle (valid&ready handshake).
REQ-009 SHALL have port bufFull, input, 1, downstream uart_tx_buffer cannot accept a byte.
REQ-010 SHALL have port data, output, 8, byte to uart_tx_buffer.
REQ-011 SHALL have port dataReady, output, 1, single-cycle write strobe to uart_tx_buffer.
REQ-012 SHALL have port grantId, output, 3, index of the current owner; valid only while busy=1.
REQ-013 SHALL have port busy, output, 1, a message is in progress.

Function
REQ-014 SHALL implement FSM states IDLE, SEND and GAP.
- IDLE: if any reqValid, grant the first requester at or after rrPtr in round-robin order, then go to SEND next cycle.
- IDLE: otherwise stay in IDLE.
REQ-015 In SEND, reqReady[g] SHALL equal reqValid[g] & ~bufFull for the granted index g; every other reqReady bit SHALL be 0 in every state.
REQ-016 On a SEND handshake:
- data and dataReady SHALL be registered, so the byte appears with dataReady=1 exactly one cycle after the handshake.
- The FSM SHALL go to GAP.
REQ-017 GAP SHALL last one cycle, forcing dataReady low between bytes, so the peak rate is 1 byte per 2 cycles.
- GAP returns to SEND if the accepted byte had reqLast=0.
- GAP returns to IDLE if the accepted byte had reqLast=1.
REQ-018 dataReady SHALL be 1 for exactly one cycle per accepted byte and never otherwise.
REQ-019 On completion of a message (reqLast accepted), rrPtr SHALL become (g+1) mod NUM_REQ.
REQ-020 A granted requester SHALL keep the grant until reqLast is accepted, regardless of other requests (no byte interleaving).
REQ-021 Idle counter:
- SHALL count SEND cycles with reqValid[g]=0.
- SHALL clear on any handshake.
- On reaching TIMEOUT, SHALL revoke the grant, return to IDLE and advance rrPtr as in REQ-019.
REQ-022 bufFull=1 SHALL stall SEND without incrementing the idle counter and without timing out.
REQ-023 busy SHALL be 1 in SEND and GAP and 0 in IDLE.
REQ-024 grantId SHALL be held stable from grant until return to IDLE.
REQ-025 Simultaneous requests SHALL resolve purely by rrPtr order.
REQ-026 Wrap-around: with rrPtr=NUM_REQ-1 and all requesters valid, requester NUM_REQ-1 SHALL win, then requester 0.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set state=IDLE, rrPtr=0, idle counter=0, data=0, dataReady=0, reqReady=0, busy=0 and grantId=0.
REQ-028 Reset mid-message SHALL abandon the message with no further dataReady; a pending registered strobe SHALL be cleared.

Structure
REQ-029 A shared package uart_pkg SHALL hold:
- the FSM state encoding,
- the default NUM_REQ/TIMEOUT constants,
- the byte width of 8.
REQ-030 The round-robin picker SHALL be one sub-module, rr_pick (inputs: request vector and pointer; outputs: index and found flag; purely combinational).
REQ-031 The arbiter SHALL connect directly to the uart_tx_buffer data/dataReady inputs; it contains no FIFO.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Single message: req0 sends 0x41,0x42,0x43 (last on 0x43), bufFull=0 -> three one-cycle dataReady strobes 2 cycles apart, data A,B,C; busy drops after GAP; rrPtr=1.
- Contention: req1 and req2 both valid from reset -> req1's full message precedes req2's; no interleaving; grantId 1 then 2.
- Backpressure: bufFull=1 for 10 cycles mid-message -> no strobes, no timeout; the byte is accepted on the cycle after bufFull falls.
- Timeout: TIMEOUT=4; req3 sends 0x44 without last, then drops valid -> return to IDLE after 4 idle SEND cycles; rrPtr=0.
- Wrap/reset: rrPtr=3 with all valid -> order 3,0,1; rst asserted during req0's second byte -> dataReady=0, busy=0 next cycle.
